seq_detector_param: RTL and testbench

Parametrised serial bit-pattern detector, the successor to the fixed 1011 Mealy detector. It adds a configurable pattern width, a pattern that can be reloaded at runtime, overlapping or non-overlapping match modes, an input-enable qualifier, Mealy and registered (Moore-timed) match outputs, and a saturating match counter. It sits on the serial input path of the sequence-detection datapath and drives match flags and statistics to downstream control.

---
 rtl/seq_detector_param_pkg.sv | 12 +
 rtl/seq_detector_param_sat_counter.sv | 23 ++
 rtl/seq_detector_param.sv | 79 +++++++
 tb/tb_seq_detector_param.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detector_param_pkg.sv
// Shared constants for the serial pattern detectors and their benches.
// Default pattern geometry, counter width and match-mode encoding.
package seq_detector_param_pkg;

  localparam int DEF_PAT_W = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;
  localparam int DEF_CNT_W = 8;

  localparam bit MODE_OVERLAP = 1'b1;
  localparam bit MODE_NONOVERLAP = 1'b0;

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating event counter shared by the statistics blocks.
// Holds at all-ones once reached; sat flags that condition.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  assign sat = &cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with reloadable pattern,
// overlap mode, Mealy and registered match outputs and match counter.
module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int          PAT_W   = DEF_PAT_W,
  parameter logic [31:0] PAT_RST = 32'(DEF_PATTERN),
  parameter bit          OVERLAP = MODE_OVERLAP,
  parameter int          CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             xin,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             zout,
  output logic             zout_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int FW = $clog2(PAT_W);
  localparam logic [FW-1:0] FULL = FW'(PAT_W - 1);

  logic [PAT_W-1:0] pat;
  logic [PAT_W-2:0] hist;
  logic [PAT_W-2:0] hist_nxt;
  logic [FW-1:0]    fill;
  logic             take;
  logic             match_now;

  assign take = rst & en & ~pat_load;
  assign match_now = take & (fill == FULL)
                   & ({hist, xin} == pat);
  assign zout = match_now;

  // A 2-bit pattern keeps a single history bit.
  generate
    if (PAT_W == 2) begin : g_w2
      assign hist_nxt = xin;
    end else begin : g_wn
      assign hist_nxt = {hist[PAT_W-3:0], xin};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat    <= PAT_RST[PAT_W-1:0];
      hist   <= '0;
      fill   <= '0;
      zout_q <= 1'b0;
    end else begin
      zout_q <= match_now;
      if (pat_load) begin
        pat  <= pat_in;
        fill <= '0;
      end else if (en) begin
        hist <= hist_nxt;
        if (match_now && OVERLAP == MODE_NONOVERLAP) begin
          fill <= '0;
        end else if (fill != FULL) begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(match_now),
    .cnt(match_cnt),
    .sat(cnt_sat)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: three detector configs share one stimulus stream.
// a: 1011 overlap, b: 1011 non-overlap, c: 1111 overlap with 2-bit count.
module tb_seq_detector_param;
  import seq_detector_param_pkg::*;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       ld;
    logic       x;
    logic [3:0] pin;
    logic [2:0] z;
  } stim_t;

  typedef struct packed {
    logic [2:0]  z;
    logic [23:0] r;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       xin = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0;

  logic       zout_a, zout_b, zout_c;
  logic       zq_a, zq_b, zq_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic       sat_a, sat_b, sat_c;

  stim_t plan[$];
  exp_t  sb[$];
  int    m_ca, m_cb, m_cc;
  int    n_run = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  seq_detector_param #(
    .OVERLAP(MODE_OVERLAP)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .xin(xin),
    .pat_load(pat_load), .pat_in(pat_in),
    .zout(zout_a), .zout_q(zq_a),
    .match_cnt(cnt_a), .cnt_sat(sat_a)
  );

  seq_detector_param #(
    .OVERLAP(MODE_NONOVERLAP)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .xin(xin),
    .pat_load(pat_load), .pat_in(pat_in),
    .zout(zout_b), .zout_q(zq_b),
    .match_cnt(cnt_b), .cnt_sat(sat_b)
  );

  seq_detector_param #(
    .PAT_RST(32'b1111),
    .OVERLAP(MODE_OVERLAP),
    .CNT_W(2)
  ) dut_c (
    .clk(clk), .rst(rst), .en(en), .xin(xin),
    .pat_load(pat_load), .pat_in(pat_in),
    .zout(zout_c), .zout_q(zq_c),
    .match_cnt(cnt_c), .cnt_sat(sat_c)
  );

  function automatic logic [2:0] comb();
    return {zout_a, zout_b, zout_c};
  endfunction

  function automatic logic [23:0] regs();
    return {zq_a, zq_b, zq_c, cnt_a, cnt_b, cnt_c,
            sat_a, sat_b, sat_c};
  endfunction

  function automatic void add(
    logic r, logic e, logic l, logic x,
    logic [3:0] p, logic [2:0] z
  );
    stim_t s;
    s = '{rst: r, en: e, ld: l, x: x, pin: p, z: z};
    plan.push_back(s);
  endfunction

  function automatic void add_bits(
    int n, logic [15:0] bits,
    logic [15:0] za, logic [15:0] zb, logic [15:0] zc
  );
    for (int i = n - 1; i >= 0; i--)
      add(1, 1, 0, bits[i], 4'b0, {za[i], zb[i], zc[i]});
  endfunction

  // Drive one cycle and queue what the outputs must show.
  task automatic drive(input stim_t s);
    exp_t e;
    rst = s.rst;
    en = s.en;
    pat_load = s.ld;
    xin = s.x;
    pat_in = s.pin;
    if (!s.rst) begin
      m_ca = 0;
      m_cb = 0;
      m_cc = 0;
      e.z = 3'b000;
    end else begin
      e.z = s.z;
      if (s.z[2] && m_ca != 255) m_ca++;
      if (s.z[1] && m_cb != 255) m_cb++;
      if (s.z[0] && m_cc != 3) m_cc++;
    end
    e.r = {e.z, 8'(m_ca), 8'(m_cb), 2'(m_cc),
           m_ca == 255, m_cb == 255, m_cc == 3};
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    plan.delete();
    add(0, 1, 0, 1, 4'b0, 3'b000);
    add(0, 1, 0, 1, 4'b0, 3'b000);
    foreach (plan[i]) begin
      drive(plan[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_run++;
      if (comb() !== e.z) begin
        n_fail++;
        $display("FAIL reset zout step %0d: got %b want %b",
                 i, comb(), e.z);
      end
      @(posedge clk);
      #1;
      n_run++;
      if (regs() !== e.r) begin
        n_fail++;
        $display("FAIL reset regs step %0d: got %h want %h",
                 i, regs(), e.r);
      end
    end
  endtask

  task automatic test_overlap();
    exp_t e;
    plan.delete();
    add(0, 1, 0, 1, 4'b0, 3'b000);
    add_bits(8, 16'b10111011, 16'b00010001,
             16'b00010001, 16'b0);
    foreach (plan[i]) begin
      drive(plan[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_run++;
      if (comb() !== e.z) begin
        n_fail++;
        $display("FAIL overlap zout step %0d: got %b want %b",
                 i, comb(), e.z);
      end
      @(posedge clk);
      #1;
      n_run++;
      if (regs() !== e.r) begin
        n_fail++;
        $display("FAIL overlap regs step %0d: got %h want %h",
                 i, regs(), e.r);
      end
    end
  endtask

  task automatic test_nonoverlap();
    exp_t e;
    plan.delete();
    add(0, 1, 0, 1, 4'b0, 3'b000);
    add_bits(7, 16'b1011011, 16'b0001001,
             16'b0001000, 16'b0);
    foreach (plan[i]) begin
      drive(plan[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_run++;
      if (comb() !== e.z) begin
        n_fail++;
        $display("FAIL nonoverlap zout step %0d: got %b want %b",
                 i, comb(), e.z);
      end
      @(posedge clk);
      #1;
      n_run++;
      if (regs() !== e.r) begin
        n_fail++;
        $display("FAIL nonoverlap regs step %0d: got %h want %h",
                 i, regs(), e.r);
      end
    end
  endtask

  task automatic test_enable_gap();
    exp_t e;
    plan.delete();
    add(0, 1, 0, 1, 4'b0, 3'b000);
    add(1, 1, 0, 1, 4'b0, 3'b000);
    add(1, 1, 0, 0, 4'b0, 3'b000);
    for (int k = 0; k < 3; k++)
      add(1, 0, 0, 1, 4'b0, 3'b000);
    add(1, 1, 0, 1, 4'b0, 3'b000);
    add(1, 1, 0, 1, 4'b0, 3'b110);
    foreach (plan[i]) begin
      drive(plan[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_run++;
      if (comb() !== e.z) begin
        n_fail++;
        $display("FAIL gap zout step %0d: got %b want %b",
                 i, comb(), e.z);
      end
      @(posedge clk);
      #1;
      n_run++;
      if (regs() !== e.r) begin
        n_fail++;
        $display("FAIL gap regs step %0d: got %h want %h",
                 i, regs(), e.r);
      end
    end
  endtask

  task automatic test_pat_load();
    exp_t e;
    plan.delete();
    add(0, 1, 0, 1, 4'b0, 3'b000);
    add_bits(3, 16'b101, 16'b0, 16'b0, 16'b0);
    add(1, 1, 1, 1, 4'b1100, 3'b000);
    add(1, 1, 0, 1, 4'b0, 3'b000);
    add(1, 1, 0, 1, 4'b0, 3'b000);
    add(1, 1, 0, 0, 4'b0, 3'b000);
    add(1, 1, 0, 0, 4'b0, 3'b111);
    foreach (plan[i]) begin
      drive(plan[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_run++;
      if (comb() !== e.z) begin
        n_fail++;
        $display("FAIL load zout step %0d: got %b want %b",
                 i, comb(), e.z);
      end
      @(posedge clk);
      #1;
      n_run++;
      if (regs() !== e.r) begin
        n_fail++;
        $display("FAIL load regs step %0d: got %h want %h",
                 i, regs(), e.r);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    plan.delete();
    add(0, 1, 0, 1, 4'b0, 3'b000);
    add_bits(3, 16'b101, 16'b0, 16'b0, 16'b0);
    add(0, 1, 1, 1, 4'b0000, 3'b000);
    add(1, 1, 0, 1, 4'b0, 3'b000);
    add_bits(3, 16'b011, 16'b001, 16'b001, 16'b0);
    foreach (plan[i]) begin
      drive(plan[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_run++;
      if (comb() !== e.z) begin
        n_fail++;
        $display("FAIL rstmid zout step %0d: got %b want %b",
                 i, comb(), e.z);
      end
      @(posedge clk);
      #1;
      n_run++;
      if (regs() !== e.r) begin
        n_fail++;
        $display("FAIL rstmid regs step %0d: got %h want %h",
                 i, regs(), e.r);
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    plan.delete();
    add(0, 1, 0, 1, 4'b0, 3'b000);
    add_bits(10, 16'b1111111111, 16'b0, 16'b0,
             16'b0001111111);
    foreach (plan[i]) begin
      drive(plan[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_run++;
      if (comb() !== e.z) begin
        n_fail++;
        $display("FAIL sat zout step %0d: got %b want %b",
                 i, comb(), e.z);
      end
      @(posedge clk);
      #1;
      n_run++;
      if (regs() !== e.r) begin
        n_fail++;
        $display("FAIL sat regs step %0d: got %h want %h",
                 i, regs(), e.r);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    m_ca = 0;
    m_cb = 0;
    m_cc = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_enable_gap();
    test_pat_load();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
